wwm_turn_ctrl: RTL and testbench

Two-player turn scheduler for the shared projectile/animation datapath. It alternates turns between P1 and P2 and accepts fire only from the active player. On fire it latches that player's velocity pair and issues a one-cycle launch to the animation engine. It then waits for hit/miss/timeout, updates scores, and declares a winner. It sits between debounced button/switch inputs and the state machine/vga_bitchange launch interface.

---
 rtl/wwm_turn_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_wwm_turn_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/wwm_turn_ctrl.sv
// Two-player turn scheduler: alternates turns, launches the active player's shot, scores results.
// Optional macro TURN_TIMER_EN adds a TURN idle timeout that forfeits the turn.
module wwm_turn_ctrl #(
    parameter int unsigned CNT_W          = 27,
    parameter int unsigned FLIGHT_TIMEOUT = 100000000,
    parameter int unsigned RESULT_HOLD    = 50000000,
    parameter int unsigned SCORE_W        = 4,
    parameter int unsigned WIN_SCORE      = 3,
    parameter int unsigned TURN_TIMEOUT   = 500000000
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic               fire_p1,
    input  logic               fire_p2,
    input  logic [7:0]         vel_p1,
    input  logic [7:0]         vel_p2,
    input  logic               hit,
    input  logic               miss,
    output logic               launch,
    output logic [3:0]         launch_vx,
    output logic [3:0]         launch_vy,
    output logic               active_player,
    output logic [SCORE_W-1:0] score_p1,
    output logic [SCORE_W-1:0] score_p2,
    output logic               winner,
    output logic               game_over,
    output logic               turn_forfeit,
    output logic               q_Idle,
    output logic               q_Turn,
    output logic               q_Launch,
    output logic               q_Flight,
    output logic               q_Result,
    output logic               q_Done
);

    // One-hot encoding so every q_* output is a flop bit.
    typedef enum logic [5:0] {
        StIdle   = 6'b000001,
        StTurn   = 6'b000010,
        StLaunch = 6'b000100,
        StFlight = 6'b001000,
        StResult = 6'b010000,
        StDone   = 6'b100000
    } state_e;

    localparam logic [CNT_W-1:0]   FlightLast = CNT_W'(FLIGHT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   ResultLast = CNT_W'(RESULT_HOLD - 1);
    localparam logic [SCORE_W-1:0] WinScore   = SCORE_W'(WIN_SCORE);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         vx_q, vx_d, vy_q, vy_d;
    logic               active_q, active_d;
    logic [SCORE_W-1:0] s1_q, s1_d, s2_q, s2_d;
    logic               winner_q, winner_d;
    logic               over_q, over_d;
    logic               fire_ok;
    logic [7:0]         fire_vel;
    logic [SCORE_W-1:0] score_act;

`ifdef TURN_TIMER_EN
    localparam logic [CNT_W-1:0] TurnLast = CNT_W'(TURN_TIMEOUT - 1);
    logic forfeit_q, forfeit_d;
`endif

    assign fire_ok   = active_q ? fire_p2 : fire_p1;
    assign fire_vel  = active_q ? vel_p2 : vel_p1;
    assign score_act = active_q ? s2_q : s1_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        vx_d     = vx_q;
        vy_d     = vy_q;
        active_d = active_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        winner_d = winner_q;
        over_d   = over_q;
`ifdef TURN_TIMER_EN
        forfeit_d = 1'b0;
`endif
        case (state_q)
            StIdle, StDone: begin
                if (Start) begin
                    state_d  = StTurn;
                    cnt_d    = '0;
                    s1_d     = '0;
                    s2_d     = '0;
                    active_d = 1'b0;
                    over_d   = 1'b0;
                end
            end
            StTurn: begin
                if (fire_ok) begin
                    vx_d    = fire_vel[7:4];
                    vy_d    = fire_vel[3:0];
                    state_d = StLaunch;
`ifdef TURN_TIMER_EN
                end else if (cnt_q == TurnLast) begin
                    forfeit_d = 1'b1;
                    active_d  = ~active_q;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
            StLaunch: begin
                cnt_d   = '0;
                state_d = StFlight;
            end
            StFlight: begin
                // hit takes precedence over miss and over the timeout
                if (hit || miss || cnt_q == FlightLast) begin
                    state_d = StResult;
                    cnt_d   = '0;
                    if (hit && score_act < WinScore) begin
                        if (active_q) s2_d = s2_q + SCORE_W'(1);
                        else          s1_d = s1_q + SCORE_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StResult: begin
                if (cnt_q == ResultLast) begin
                    cnt_d = '0;
                    if (score_act == WinScore) begin
                        state_d  = StDone;
                        winner_d = active_q;
                        over_d   = 1'b1;
                    end else begin
                        state_d  = StTurn;
                        active_d = ~active_q;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            vx_q     <= '0;
            vy_q     <= '0;
            active_q <= 1'b0;
            s1_q     <= '0;
            s2_q     <= '0;
            winner_q <= 1'b0;
            over_q   <= 1'b0;
`ifdef TURN_TIMER_EN
            forfeit_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            vx_q     <= vx_d;
            vy_q     <= vy_d;
            active_q <= active_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            winner_q <= winner_d;
            over_q   <= over_d;
`ifdef TURN_TIMER_EN
            forfeit_q <= forfeit_d;
`endif
        end
    end

`ifdef TURN_TIMER_EN
    assign turn_forfeit = forfeit_q;
`else
    assign turn_forfeit = 1'b0;
`endif

    assign launch        = state_q[2];
    assign launch_vx     = vx_q;
    assign launch_vy     = vy_q;
    assign active_player = active_q;
    assign score_p1      = s1_q;
    assign score_p2      = s2_q;
    assign winner        = winner_q;
    assign game_over     = over_q;
    assign q_Idle        = state_q[0];
    assign q_Turn        = state_q[1];
    assign q_Launch      = state_q[2];
    assign q_Flight      = state_q[3];
    assign q_Result      = state_q[4];
    assign q_Done        = state_q[5];

endmodule

// File: tb/tb_wwm_turn_ctrl.sv
// Bench for wwm_turn_ctrl: directed table, corner sequences and random stimulus vs a phase model.
// Honours TURN_TIMER_EN the same way as the design.
module tb_wwm_turn_ctrl;

    localparam int FT = 20;
    localparam int RH = 4;
    localparam int WS = 2;
    localparam int TT = 10;

    localparam int PIdle   = 0;
    localparam int PTurn   = 1;
    localparam int PLaunch = 2;
    localparam int PFlight = 3;
    localparam int PResult = 4;
    localparam int PDone   = 5;

    logic       clk = 1'b0;
    logic       Reset, Start, fire_p1, fire_p2, hit, miss;
    logic [7:0] vel_p1, vel_p2;
    logic       launch, active_player, winner, game_over, turn_forfeit;
    logic [3:0] launch_vx, launch_vy, score_p1, score_p2;
    logic       q_Idle, q_Turn, q_Launch, q_Flight, q_Result, q_Done;

    wwm_turn_ctrl #(
        .CNT_W(8), .FLIGHT_TIMEOUT(FT), .RESULT_HOLD(RH), .SCORE_W(4),
        .WIN_SCORE(WS), .TURN_TIMEOUT(TT)
    ) dut (
        .clk(clk), .Reset(Reset), .Start(Start), .fire_p1(fire_p1), .fire_p2(fire_p2),
        .vel_p1(vel_p1), .vel_p2(vel_p2), .hit(hit), .miss(miss), .launch(launch),
        .launch_vx(launch_vx), .launch_vy(launch_vy), .active_player(active_player),
        .score_p1(score_p1), .score_p2(score_p2), .winner(winner), .game_over(game_over),
        .turn_forfeit(turn_forfeit), .q_Idle(q_Idle), .q_Turn(q_Turn), .q_Launch(q_Launch),
        .q_Flight(q_Flight), .q_Result(q_Result), .q_Done(q_Done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Game model: phase plus cycles remaining in the current timed phase.
    int m_phase, m_left, m_turn, m_vx, m_vy, m_winner, m_over, m_forfeit;
    int m_score[2];

    function automatic logic [26:0] model_word();
        logic [5:0] q;
        q = 6'(1 << m_phase);
        return {m_phase == PLaunch, 4'(m_vx), 4'(m_vy), 1'(m_turn), 4'(m_score[0]),
                4'(m_score[1]), 1'(m_winner), 1'(m_over), 1'(m_forfeit), q};
    endfunction

    function automatic logic [26:0] dut_word();
        return {launch, launch_vx, launch_vy, active_player, score_p1, score_p2, winner,
                game_over, turn_forfeit, q_Done, q_Result, q_Flight, q_Launch, q_Turn, q_Idle};
    endfunction

    task automatic check(input string name, input logic [26:0] act, input logic [26:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = PIdle; m_left = 0; m_turn = 0; m_vx = 0; m_vy = 0;
        m_winner = 0; m_over = 0; m_forfeit = 0; m_score[0] = 0; m_score[1] = 0;
    endtask

    task automatic model_step(input logic s, f1, f2, input logic [7:0] v1, v2,
                              input logic h, m);
        logic       f;
        logic [7:0] v;
        m_forfeit = 0;
        case (m_phase)
            PIdle, PDone: if (s) begin
                m_phase = PTurn; m_left = TT; m_turn = 0; m_over = 0;
                m_score[0] = 0; m_score[1] = 0;
            end
            PTurn: begin
                f = (m_turn == 1) ? f2 : f1;
                v = (m_turn == 1) ? v2 : v1;
                if (f) begin
                    m_vx = int'(v[7:4]); m_vy = int'(v[3:0]); m_phase = PLaunch;
                end else begin
`ifdef TURN_TIMER_EN
                    m_left--;
                    if (m_left == 0) begin
                        m_forfeit = 1; m_turn = 1 - m_turn; m_left = TT;
                    end
`endif
                end
            end
            PLaunch: begin
                m_phase = PFlight; m_left = FT;
            end
            PFlight: begin
                m_left--;
                if (h || m || m_left == 0) begin
                    if (h && m_score[m_turn] < WS) m_score[m_turn]++;
                    m_phase = PResult; m_left = RH;
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) begin
                    if (m_score[m_turn] == WS) begin
                        m_phase = PDone; m_winner = m_turn; m_over = 1;
                    end else begin
                        m_phase = PTurn; m_turn = 1 - m_turn; m_left = TT;
                    end
                end
            end
        endcase
    endtask

    task automatic cycle(input string name, input logic s, f1, f2, input logic [7:0] v1, v2,
                         input logic h, m);
        @(negedge clk);
        Start = s; fire_p1 = f1; fire_p2 = f2; vel_p1 = v1; vel_p2 = v2; hit = h; miss = m;
        @(posedge clk);
        model_step(s, f1, f2, v1, v2, h, m);
        #1;
        check(name, dut_word(), model_word());
    endtask

    task automatic idle(input string name);
        cycle(name, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        Start = 0; fire_p1 = 0; fire_p2 = 0; hit = 0; miss = 0;
        #2 Reset = 1'b1;
        #1 model_reset();
        check("async_reset", dut_word(), 27'd1);
        @(negedge clk);
        Reset = 1'b0;
        #1 check("reset_hold", dut_word(), model_word());
    endtask

    typedef struct {
        logic       s, f1, f2;
        logic [7:0] v1, v2;
        logic       h, m;
        logic [5:0] q;
        logic       l;
        logic [3:0] vx, vy;
        logic       ap;
        logic [3:0] s1;
    } vec_t;

    vec_t tbl[9];

    initial begin
        Reset = 1'b1; Start = 0; fire_p1 = 0; fire_p2 = 0; hit = 0; miss = 0;
        vel_p1 = 8'h00; vel_p2 = 8'h00;
        model_reset();
        #1 check("reset_state", dut_word(), 27'd1);
        @(negedge clk);
        Reset = 1'b0;

        // Start, ignored P2 fire, simultaneous fire, launch, hit+miss, result hold
        tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 6'b000010, 1'b0, 4'h0, 4'h0, 1'b0, 4'd0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'hC3, 1'b0, 1'b0, 6'b000010, 1'b0, 4'h0, 4'h0, 1'b0, 4'd0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 8'h5A, 8'hC3, 1'b0, 1'b0, 6'b000100, 1'b1, 4'h5, 4'hA, 1'b0, 4'd0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 8'h5A, 8'h00, 1'b0, 1'b0, 6'b001000, 1'b0, 4'h5, 4'hA, 1'b0, 4'd0};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 6'b010000, 1'b0, 4'h5, 4'hA, 1'b0, 4'd1};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 6'b010000, 1'b0, 4'h5, 4'hA, 1'b0, 4'd1};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 6'b010000, 1'b0, 4'h5, 4'hA, 1'b0, 4'd1};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 6'b010000, 1'b0, 4'h5, 4'hA, 1'b0, 4'd1};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 6'b000010, 1'b0, 4'h5, 4'hA, 1'b1, 4'd1};
        for (int i = 0; i < 9; i++) begin
            cycle("tbl_model", tbl[i].s, tbl[i].f1, tbl[i].f2, tbl[i].v1, tbl[i].v2,
                  tbl[i].h, tbl[i].m);
            check($sformatf("tbl_%0d", i),
                  27'({q_Done, q_Result, q_Flight, q_Launch, q_Turn, q_Idle, launch,
                       launch_vx, launch_vy, active_player, score_p1}),
                  27'({tbl[i].q, tbl[i].l, tbl[i].vx, tbl[i].vy, tbl[i].ap, tbl[i].s1}));
        end

        // P2 flight times out after 20 cycles; Start/fire/hit ignored where they do not apply
        cycle("p2_fire", 1'b0, 1'b0, 1'b1, 8'hFF, 8'h37, 1'b0, 1'b0);
        check("p2_launch", 27'({launch, launch_vx, launch_vy}), 27'({1'b1, 4'h3, 4'h7}));
        idle("flight_enter");
        for (int i = 0; i < 19; i++)
            cycle("flight_wait", i == 5, i == 7, 1'b0, 8'h11, 8'h00, 1'b0, 1'b0);
        check("flight_still", 27'({q_Flight, q_Result}), 27'({1'b1, 1'b0}));
        idle("flight_timeout");
        check("timeout_result", 27'({q_Result, score_p2}), 27'({1'b1, 4'd0}));
        cycle("result_hit_ignored", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) idle("result_hold");
        check("back_to_p1", 27'({q_Turn, active_player, score_p1, score_p2}),
              27'({1'b1, 1'b0, 4'd1, 4'd0}));

        // P1 second hit wins the game, then restart
        cycle("p1_fire2", 1'b0, 1'b1, 1'b0, 8'h9E, 8'h00, 1'b0, 1'b0);
        idle("flight2");
        cycle("hit2", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) idle("result2");
        check("game_done", 27'({q_Done, game_over, winner, score_p1}),
              27'({1'b1, 1'b1, 1'b0, 4'd2}));
        cycle("done_hit_ignored", 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        cycle("restart", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        check("restart_state", 27'({q_Turn, score_p1, score_p2, active_player, game_over}),
              27'({1'b1, 4'd0, 4'd0, 1'b0, 1'b0}));

`ifdef TURN_TIMER_EN
        for (int i = 0; i < 9; i++) idle("turn_wait");
        idle("turn_timeout");
        check("forfeit_pulse", 27'({turn_forfeit, active_player, q_Turn}),
              27'({1'b1, 1'b1, 1'b1}));
        idle("forfeit_end");
        check("forfeit_once", 27'(turn_forfeit), 27'(1'b0));
`else
        for (int i = 0; i < 100; i++) idle("turn_wait");
        check("no_forfeit", 27'({turn_forfeit, q_Turn, active_player}),
              27'({1'b0, 1'b1, 1'b0}));
`endif

        // Reset in the middle of a flight
        cycle("fire_any", 1'b0, 1'b1, 1'b1, 8'h42, 8'h24, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) idle("pre_reset_flight");
        check("in_flight", 27'(q_Flight), 27'(1'b1));
        do_reset();

        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 699) do_reset();
            cycle("random", ($urandom % 40) == 0, ($urandom % 6) == 0, ($urandom % 6) == 0,
                  8'($urandom), 8'($urandom), ($urandom % 10) == 0, ($urandom % 12) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
